// File: rtl/unshift_decode_unit.sv
// Iterative inverse-shift decoder with priority-encoder consistency check.
// Optional macro UNSHIFT_FAST_EN replaces the bit-serial shift with a single-cycle barrel inverse.
module unshift_decode_unit #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [SHW-1:0]   in_pe_idx,
    input  logic             in_pe_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_lossy,
    output logic             out_pe_mismatch,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for an input transaction
    // SHIFT | applying the inverse shift, one position per edge
    // DONE  | result presented, waiting for out_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Inverse op codes; numerically equal to the forward mode they undo.
    localparam logic [1:0] OP_LSR  = 2'b00;
    localparam logic [1:0] OP_LSL  = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_onehot;
    logic             r_lossy;
    logic             r_mismatch;

    logic [WIDTH-1:0] w_onehot;
    logic [SHW-1:0]   w_msb;
    logic             w_nonzero;
    logic             w_mismatch;
    logic             w_lossy;

    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] d, input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_LSR:  r = d >> 1;
            OP_LSL:  r = d << 1;
            OP_ROTR: r = {d[0], d[WIDTH-1:1]};
            default: r = {d[WIDTH-2:0], d[WIDTH-1]};
        endcase
        return r;
    endfunction

`ifdef UNSHIFT_FAST_EN
    function automatic logic [WIDTH-1:0] f_barrel(input logic [WIDTH-1:0] d,
                                                   input logic [SHW-1:0] n,
                                                   input logic [1:0] op);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(n)) r = f_step(r, op);
        end
        return r;
    endfunction
`endif

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_data[i]) w_msb = SHW'(i);
        end
    end

    assign w_nonzero  = |in_data;
    assign w_onehot   = in_pe_valid ? (WIDTH'(1) << in_pe_idx) : '0;
    assign w_lossy    = ~in_mode[1] && (in_shamt != '0);
    assign w_mismatch = (in_pe_valid != w_nonzero) || (in_pe_valid && (in_pe_idx != w_msb));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_op       <= OP_LSR;
            r_onehot   <= '0;
            r_lossy    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef UNSHIFT_FAST_EN
                        // Barrel result lands now; cnt=1 holds SHIFT for a fixed 2-edge latency.
                        r_work <= f_barrel(in_data, in_shamt, in_mode);
                        r_cnt  <= SHW'(1);
`else
                        r_work <= in_data;
                        r_cnt  <= in_shamt;
`endif
                        r_op       <= in_mode;
                        r_onehot   <= w_onehot;
                        r_lossy    <= w_lossy;
                        r_mismatch <= w_mismatch;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
`ifndef UNSHIFT_FAST_EN
                        r_work <= f_step(r_work, r_op);
`endif
                        r_cnt  <= r_cnt - SHW'(1);
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready        = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign out_valid       = (r_state == S_DONE);
    assign out_data        = r_work;
    assign out_onehot      = r_onehot;
    assign out_lossy       = r_lossy;
    assign out_pe_mismatch = r_mismatch;

endmodule

// File: tb/tb_unshift_decode_unit.sv
// Directed and randomised bench for unshift_decode_unit against an arithmetic reference model.
module tb_unshift_decode_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_shamt;
    logic [1:0]   in_mode;
    logic [2:0]   in_pe_idx;
    logic         in_pe_valid;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] out_onehot;
    logic         out_lossy;
    logic         out_pe_mismatch;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_data;
    int last_mm;

    unshift_decode_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_pe_idx(in_pe_idx),
        .in_pe_valid(in_pe_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_onehot(out_onehot), .out_lossy(out_lossy),
        .out_pe_mismatch(out_pe_mismatch), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rot_l(int d, int s);
        return ((d << s) | (d >> (W - s))) & 255;
    endfunction
    function automatic int rot_r(int d, int s);
        return ((d >> s) | (d << (W - s))) & 255;
    endfunction
    // Forward encoder: 0 lsl, 1 lsr, 2 rotl, 3 rotr.
    function automatic int ref_encode(int d, int s, int m);
        case (m)
            0: return (d << s) & 255;
            1: return d >> s;
            2: return rot_l(d, s);
            default: return rot_r(d, s);
        endcase
    endfunction
    function automatic int ref_unshift(int d, int s, int m);
        case (m)
            0: return d >> s;
            1: return (d << s) & 255;
            2: return rot_r(d, s);
            default: return rot_l(d, s);
        endcase
    endfunction
    function automatic int ref_msb(int d);
        return $clog2(d + 1) - 1;
    endfunction
    function automatic int ref_latency(int s);
`ifdef UNSHIFT_FAST_EN
        return 2;
`else
        return s + 1;
`endif
    endfunction

    task automatic run_txn(input int d, input int s, input int m, input int idx, input int v,
                           input string tag);
        int k;
        int exp_mm;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "_ready"}, in_ready, 1);
        in_data = W'(d); in_shamt = 3'(s); in_mode = 2'(m);
        in_pe_idx = 3'(idx); in_pe_valid = v[0]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
        exp_mm = ((v != 0) != (d != 0)) || (v != 0 && idx != ref_msb(d));
        chk({tag, "_latency"}, k, ref_latency(s));
        chk({tag, "_data"},    out_data, ref_unshift(d, s, m));
        chk({tag, "_onehot"},  out_onehot, (v != 0) ? (1 << idx) : 0);
        chk({tag, "_lossy"},   out_lossy, (m < 2 && s != 0) ? 1 : 0);
        chk({tag, "_mm"},      out_pe_mismatch, exp_mm);
        chk({tag, "_busy"},    busy, 1);
        last_data = int'(out_data);
        last_mm   = int'(out_pe_mismatch);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"},    {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_mode = '0; in_pe_idx = '0; in_pe_valid = 1'b0;
        #2;
        chk("rst_outs", {out_valid, out_data, out_onehot, out_lossy, out_pe_mismatch, busy}, 0);
        chk("rst_ready", in_ready, 1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        run_txn('h2D, 3, 2, 5, 1, "tp1");
        chk("tp1_const", last_data, 'hA5);
        run_txn('h28, 2, 0, 3, 1, "tp2a");
        chk("tp2a_const", last_data, 'h0A);
        run_txn('h81, 0, 3, 7, 1, "tp2b");
        run_txn('h40, 1, 2, 6, 1, "tp3a");
        chk("tp3a_const", last_mm, 0);
        run_txn('h40, 1, 2, 5, 1, "tp3b");
        chk("tp3b_const", last_mm, 1);
        run_txn('h40, 1, 2, 6, 0, "tp3c");
        chk("tp3c_const", last_mm, 1);
        run_txn('h00, 4, 3, 2, 0, "tp3d");

        // Backpressure with a competing input held valid.
        in_data = 8'h96; in_shamt = 3'd1; in_mode = 2'b11; in_pe_idx = 3'd7; in_pe_valid = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h3C; in_shamt = 3'd5; in_mode = 2'b00; in_pe_valid = 1'b0;
        repeat (ref_latency(1)) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {out_valid, in_ready}, 2'b10);
            chk("bp_data", out_data, rot_l('h96, 1));
            chk("bp_flags", {out_onehot, out_lossy, out_pe_mismatch}, {8'h80, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", {in_ready, busy, out_valid}, 3'b100);

        // Reset partway through a long rotate.
        in_data = 8'h5A; in_shamt = 3'd7; in_mode = 2'b10; in_pe_idx = 3'd6; in_pe_valid = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst", {out_valid, busy, out_data, in_ready}, {1'b0, 1'b0, 8'h00, 1'b1});
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_txn('h5A, 7, 2, 6, 1, "post_rst");

        for (int t = 0; t < 200; t++) begin
            int orig, s, m, enc;
            orig = int'($urandom_range(0, 255));
            s    = int'($urandom_range(0, 7));
            m    = int'($urandom_range(0, 3));
            enc  = ref_encode(orig, s, m);
            run_txn(enc, s, m, (enc != 0) ? ref_msb(enc) : int'($urandom_range(0, 7)),
                    (enc != 0) ? 1 : 0, "rnd");
            chk("rnd_mm0", last_mm, 0);
            if (m >= 2) chk("rnd_orig", last_data, orig);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
